// File: rtl/alu_operand_stage.sv
// ALU operand select followed by a valid/ready stage with a 2-entry skid FIFO.
// Optional operand forwarding is enabled by defining ALUSRC_FWD_EN.
module alu_operand_stage #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CONST_VAL  = 32'd16,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] regsrc_a,
    input  logic [WIDTH-1:0] regsrc_b,
    input  logic [WIDTH-1:0] immsrc,
    input  logic [1:0]       alusrc,
`ifdef ALUSRC_FWD_EN
    input  logic [1:0]       fwd_sel_a,
    input  logic [1:0]       fwd_sel_b,
    input  logic [WIDTH-1:0] fwd_exmem,
    input  logic [WIDTH-1:0] fwd_memwb,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic             illegal_sel,
    output logic [1:0]       occupancy
);

    if (SKID_DEPTH != 2) begin : g_bad_skid_depth
        $error("alu_operand_stage: SKID_DEPTH must be 2");
    end

    localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST_VAL);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ill;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '{a: {WIDTH{1'b0}}, b: {WIDTH{1'b0}}, ill: 1'b0};

    state_t state_q, state_d;
    entry_t e0_q, e0_d, e1_q, e1_d;
    entry_t new_s;
    logic   push_s, pop_s;
    logic [WIDTH-1:0] b_reg_s;

    // Operand selection; illegal codes drive zero/no-forward and flag the pair.
    always_comb begin
        new_s     = ENTRY_ZERO;
        new_s.a   = regsrc_a;
        b_reg_s   = regsrc_b;
`ifdef ALUSRC_FWD_EN
        case (fwd_sel_a)
            2'b00:   new_s.a = regsrc_a;
            2'b01:   new_s.a = fwd_exmem;
            2'b10:   new_s.a = fwd_memwb;
            default: new_s.ill = 1'b1;
        endcase
        // B forwarding only matters when the register path is selected.
        if (alusrc == 2'b00) begin
            case (fwd_sel_b)
                2'b00:   b_reg_s = regsrc_b;
                2'b01:   b_reg_s = fwd_exmem;
                2'b10:   b_reg_s = fwd_memwb;
                default: new_s.ill = 1'b1;
            endcase
        end else begin
            b_reg_s = regsrc_b;
        end
`endif
        case (alusrc)
            2'b00:   new_s.b = b_reg_s;
            2'b01:   new_s.b = immsrc;
            2'b10:   new_s.b = CONST_W;
            default: begin
                new_s.b   = {WIDTH{1'b0}};
                new_s.ill = 1'b1;
            end
        endcase
    end

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // FIFO next state: entry 0 is always the head; vacated slots are zeroed.
    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        case (state_q)
            EMPTY: begin
                if (push_s) begin
                    e0_d    = new_s;
                    state_d = ONE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    e0_d = new_s;
                end else if (push_s) begin
                    e1_d    = new_s;
                    state_d = FULL;
                end else if (pop_s) begin
                    e0_d    = ENTRY_ZERO;
                    state_d = EMPTY;
                end else begin
                    state_d = ONE;
                end
            end
            FULL: begin
                if (pop_s) begin
                    e0_d    = e1_q;
                    e1_d    = ENTRY_ZERO;
                    state_d = ONE;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
                e0_d    = ENTRY_ZERO;
                e1_d    = ENTRY_ZERO;
            end
        endcase
    end

    // State and buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            e0_q    <= ENTRY_ZERO;
            e1_q    <= ENTRY_ZERO;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign operand_a   = e0_q.a;
    assign operand_b   = e0_q.b;
    assign illegal_sel = e0_q.ill;
    assign occupancy   = state_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage against a queue-based model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, illegal_sel;
    logic [31:0] regsrc_a, regsrc_b, immsrc, operand_a, operand_b;
    logic [1:0]  alusrc, occupancy;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic [31:0] fwd_exmem, fwd_memwb;

    // WIDTH=16 sweep instances
    logic        p_valid, p_in_ready_a, p_in_ready_b, p_ov_a, p_ov_b, p_ill_a, p_ill_b;
    logic [15:0] p_zero, p_opa_a, p_opb_a, p_opa_b, p_opb_b;
    logic [1:0]  p_sel, p_occ_a, p_occ_b;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } pair_t;

    pair_t mq[$];

    always #5 clk = ~clk;

    alu_operand_stage #(.WIDTH(32), .CONST_VAL(16), .SKID_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .regsrc_a(regsrc_a), .regsrc_b(regsrc_b), .immsrc(immsrc), .alusrc(alusrc),
`ifdef ALUSRC_FWD_EN
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .operand_a(operand_a),
        .operand_b(operand_b), .illegal_sel(illegal_sel), .occupancy(occupancy)
    );

    alu_operand_stage #(.WIDTH(16), .CONST_VAL(20), .SKID_DEPTH(2)) dut16a (
        .clk(clk), .rst_n(rst_n), .in_valid(p_valid), .in_ready(p_in_ready_a),
        .regsrc_a(p_zero), .regsrc_b(p_zero), .immsrc(p_zero), .alusrc(p_sel),
`ifdef ALUSRC_FWD_EN
        .fwd_sel_a(2'b00), .fwd_sel_b(2'b00), .fwd_exmem(p_zero), .fwd_memwb(p_zero),
`endif
        .out_valid(p_ov_a), .out_ready(1'b1), .operand_a(p_opa_a),
        .operand_b(p_opb_a), .illegal_sel(p_ill_a), .occupancy(p_occ_a)
    );

    alu_operand_stage #(.WIDTH(16), .CONST_VAL(32'h12345), .SKID_DEPTH(2)) dut16b (
        .clk(clk), .rst_n(rst_n), .in_valid(p_valid), .in_ready(p_in_ready_b),
        .regsrc_a(p_zero), .regsrc_b(p_zero), .immsrc(p_zero), .alusrc(p_sel),
`ifdef ALUSRC_FWD_EN
        .fwd_sel_a(2'b00), .fwd_sel_b(2'b00), .fwd_exmem(p_zero), .fwd_memwb(p_zero),
`endif
        .out_valid(p_ov_b), .out_ready(1'b1), .operand_a(p_opa_b),
        .operand_b(p_opb_b), .illegal_sel(p_ill_b), .occupancy(p_occ_b)
    );

    // What the selection rules say the current inputs should produce.
    function automatic pair_t expected_pair();
        pair_t p;
        logic [31:0] reg_b;
        p.ill = 1'b0;
        p.a   = regsrc_a;
        reg_b = regsrc_b;
`ifdef ALUSRC_FWD_EN
        if (fwd_sel_a == 2'd1) p.a = fwd_exmem;
        if (fwd_sel_a == 2'd2) p.a = fwd_memwb;
        if (fwd_sel_a == 2'd3) p.ill = 1'b1;
        if (alusrc == 2'd0 && fwd_sel_b == 2'd1) reg_b = fwd_exmem;
        if (alusrc == 2'd0 && fwd_sel_b == 2'd2) reg_b = fwd_memwb;
        if (alusrc == 2'd0 && fwd_sel_b == 2'd3) p.ill = 1'b1;
`endif
        if (alusrc == 2'd0)      p.b = reg_b;
        else if (alusrc == 2'd1) p.b = immsrc;
        else if (alusrc == 2'd2) p.b = 32'd16;
        else begin
            p.b   = 32'd0;
            p.ill = 1'b1;
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_state();
        chk("out_valid", {31'd0, out_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
        chk("in_ready", {31'd0, in_ready}, (mq.size() < 2) ? 32'd1 : 32'd0);
        chk("occupancy", {30'd0, occupancy}, mq.size());
        if (mq.size() != 0) begin
            chk("operand_a", operand_a, mq[0].a);
            chk("operand_b", operand_b, mq[0].b);
            chk("illegal_sel", {31'd0, illegal_sel}, {31'd0, mq[0].ill});
        end
    endtask

    // One clock: decide transfers from the model, advance it after the edge, compare.
    task automatic step();
        bit    push, pop;
        pair_t np;
        push = in_valid && (mq.size() < 2);
        pop  = out_ready && (mq.size() > 0);
        np   = expected_pair();
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(np);
        check_state();
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [1:0] sel);
        regsrc_a = a;
        regsrc_b = b;
        immsrc   = imm;
        alusrc   = sel;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 2'b00);
        fwd_sel_a = 2'b00; fwd_sel_b = 2'b00; fwd_exmem = 32'd0; fwd_memwb = 32'd0;
        p_valid = 1'b0; p_zero = 16'd0; p_sel = 2'b10;
        repeat (2) @(negedge clk);
        check_state();
        chk("rst_operand_a", operand_a, 32'd0);
        rst_n = 1'b1;

        // Select coverage, one pair at a time with the sink ready.
        out_ready = 1'b1; in_valid = 1'b1;
        drive(32'd11, 32'hDEADBEEF, 32'd0, 2'b00); step();
        chk("sel_reg", operand_b, 32'hDEADBEEF);
        drive(32'd12, 32'd0, 32'hFFFF8000, 2'b01); step();
        chk("sel_imm", operand_b, 32'hFFFF8000);
        drive(32'd13, 32'd5, 32'd6, 2'b10); step();
        chk("sel_const", operand_b, 32'd16);
        drive(32'd14, 32'd5, 32'd6, 2'b11); step();
        chk("sel_illegal_b", operand_b, 32'd0);
        chk("sel_illegal_flag", {31'd0, illegal_sel}, 32'd1);
        in_valid = 1'b0; step();

        // WIDTH=16 constant and truncation.
        @(negedge clk); p_valid = 1'b1;
        @(posedge clk); #1; p_valid = 1'b0;
        chk("w16_valid", {31'd0, p_ov_a}, 32'd1);
        chk("w16_const20", {16'd0, p_opb_a}, 32'h0014);
        chk("w16_trunc", {16'd0, p_opb_b}, 32'h2345);

        // Backpressure: three pushes against a stalled sink, then drain.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'd1, 32'd0, 32'd0, 2'b00); step();
        drive(32'd2, 32'd0, 32'd0, 2'b00); step();
        drive(32'd3, 32'd0, 32'd0, 2'b00); step(); step();
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_head_held", operand_a, 32'd1);
        out_ready = 1'b1; step(); step();
        in_valid = 1'b0; step(); step();
        chk("bp_drained", {30'd0, occupancy}, 32'd0);

        // Streaming at full rate.
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(i, 32'd0, 32'd0, 2'b00);
            step();
            chk("stream_a", operand_a, i);
        end
        in_valid = 1'b0; step();

        // Asynchronous reset with the buffer full.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'd21, 32'd0, 32'd0, 2'b01); step();
        drive(32'd22, 32'd0, 32'd0, 2'b10); step();
        chk("pre_rst_occ", {30'd0, occupancy}, 32'd2);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        mq.delete();
        check_state();
        chk("rst_mid_a", operand_a, 32'd0);
        chk("rst_mid_b", operand_b, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        drive(32'd99, 32'd0, 32'd0, 2'b00); out_ready = 1'b1; step();
        chk("post_rst_push", operand_a, 32'd99);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
`ifdef ALUSRC_FWD_EN
            fwd_sel_a = 2'($urandom_range(0, 3)); fwd_sel_b = 2'($urandom_range(0, 3));
            fwd_exmem = $urandom; fwd_memwb = $urandom;
`endif
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered, parametrised successor of the ALU source mux.
- Selects both ALU operands and pushes them through a valid/ready pipeline stage with a 2-entry skid buffer.
- Operand B source: register, immediate, or the constant CONST_VAL. Operand A is always the register value.
- Sits between the decode/register-file stage and the ALU. Supports stall backpressure without dropping or duplicating operands.

Parameters:
- WIDTH, 32, datapath width of all operands.
- CONST_VAL, 16, constant driven on operand B when alusrc=2'b10; truncated to WIDTH.
- SKID_DEPTH, 2, fixed at 2; any other value is a compile-time error via generate check.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has a valid operand set
- in_ready  output  1  stage can accept a transfer
- regsrc_a  input  WIDTH  register-file value for operand A
- regsrc_b  input  WIDTH  register-file value for operand B
- immsrc  input  WIDTH  sign/zero-extended immediate
- alusrc  input  2  operand B select: 00 reg, 01 imm, 10 CONST_VAL, 11 illegal
- fwd_sel_a  input  2  operand A forwarding select (ALUSRC_FWD_EN only): 00 none, 01 EX/MEM, 10 MEM/WB, 11 illegal
- fwd_sel_b  input  2  operand B forwarding select (ALUSRC_FWD_EN only), same encoding as fwd_sel_a
- fwd_exmem  input  WIDTH  EX/MEM forwarded result (ALUSRC_FWD_EN only)
- fwd_memwb  input  WIDTH  MEM/WB forwarded result (ALUSRC_FWD_EN only)
- out_valid  output  1  operand pair valid
- out_ready  input  1  ALU accepts the operand pair
- operand_a  output  WIDTH  selected operand A
- operand_b  output  WIDTH  selected operand B
- illegal_sel  output  1  registered alongside the pair; set if that pair used an illegal select code
- occupancy  output  2  number of entries held (0..2)

Behaviour:
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Selection is combinational on input; the result is captured into the buffer only on an input transfer.
- alusrc=11 yields operand_b=0 and sets illegal_sel for that entry. No X is ever propagated.
- Buffer is a 2-entry FIFO: head drives operand_a, operand_b and illegal_sel; out_valid = (occupancy != 0).
- in_ready = (occupancy < 2). It is a registered function of occupancy and does not combinationally depend on out_ready.
- Latency: 1 cycle minimum, input transfer at edge N gives out_valid high after edge N.
- Throughput: 1 pair/cycle while out_ready stays high.
- States, equal to occupancy:
  - EMPTY(0): input transfer -> ONE.
  - ONE(1): input only -> FULL; output only -> EMPTY; both -> ONE, head replaced by new pair.
  - FULL(2): output only -> ONE with second entry promoted; input is not possible since in_ready=0.
- Simultaneous input and output in ONE must preserve order: the new pair becomes head only after the old head leaves.
- While out_valid=1 and out_ready=0, the head outputs are held stable.
- Reset (asynchronous, any time, including mid-transfer):
  - occupancy=0, out_valid=0, in_ready=1 after deassertion;
  - operand_a=0, operand_b=0, illegal_sel=0;
  - buffer contents cleared to 0.
- First input transfer is accepted on the first rising edge after rst_n deasserts.

Optional Feature:
- ALUSRC_FWD_EN defined:
  - fwd_sel_a/fwd_sel_b and fwd_exmem/fwd_memwb ports exist.
  - Operand A = fwd_exmem/fwd_memwb/regsrc_a per fwd_sel_a.
  - For operand B, forwarding replaces only the register path and applies only when alusrc=00; the immediate and constant paths are unaffected.
  - fwd_sel=11 is treated as no forwarding and sets illegal_sel.
- ALUSRC_FWD_EN undefined: forwarding ports absent; operands come straight from regsrc_a/regsrc_b/immsrc/CONST_VAL.

Test Plan:
- Reset mid-stream: assert rst_n=0 with occupancy=2 -> out_valid=0, in_ready=1, operand_a=operand_b=0 immediately; the first post-reset push appears next cycle.
- Select coverage, WIDTH=32:
  - regsrc_b=0xDEADBEEF, alusrc=00 -> operand_b=0xDEADBEEF.
  - immsrc=0xFFFF8000, alusrc=01 -> operand_b=0xFFFF8000.
  - alusrc=10 -> operand_b=16.
  - alusrc=11 -> operand_b=0, illegal_sel=1.
- Backpressure: out_ready=0, push A=1, A=2, A=3 -> in_ready drops after 2 pushes; the third pair is held upstream. Then out_ready=1 -> pops 1, 2, 3 in order with no loss or duplicate.
- Streaming: out_ready=1, 8 back-to-back pushes A=0..7 -> out_valid every cycle after the first; outputs 0..7 at 1-cycle latency; occupancy stays ≤1.
- Forwarding (ALUSRC_FWD_EN): regsrc_a=5, fwd_exmem=9, fwd_sel_a=01 -> operand_a=9. With fwd_sel_b=10, alusrc=01, immsrc=7 -> operand_b=7 (immediate wins).
- Parameter sweep: WIDTH=16, CONST_VAL=20 -> alusrc=10 gives operand_b=0x0014; CONST_VAL=0x12345 gives 0x2345 (truncated).
